// File: rtl/adder_seq_pkg.sv
// rtl/adder_seq_pkg.sv - FSM state type and encodings for the sequential slice adder
package adder_seq_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        RUN  = ST_RUN,
        DONE = ST_DONE
    } state_t;

endpackage

// File: rtl/adder_rc.sv
// rtl/adder_rc.sv - N-bit ripple-carry adder slice shared by the sequencer
module adder_rc #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         ci,
    output logic [N-1:0] s,
    output logic         co
);

    always_comb begin
        logic carry;
        carry = ci;
        s     = '0;
        for (int i = 0; i < N; i++) begin
            s[i]  = a[i] ^ b[i] ^ carry;
            carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        co = carry;
    end

endmodule

// File: rtl/adder_seq_ctrl.sv
// rtl/adder_seq_ctrl.sv - W=N*M bit adder time-sharing one N-bit slice over M cycles
// Optional ADDER_SEQ_SUB_EN adds a sub input selecting a - b.
module adder_seq_ctrl
    import adder_seq_pkg::*;
#(
    parameter int N = 4,
    parameter int M = 4,
    localparam int W = N * M
) (
    input  logic         clock,
    input  logic         reset,
`ifdef ADDER_SEQ_SUB_EN
    input  logic         sub,
`endif
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] s,
    output logic         co
);

    localparam int KW = $clog2(M);
    localparam logic [KW-1:0] K_LAST = KW'(M - 1);

    state_t        state_q, state_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [W-N-1:0] r_q, r_d;
    logic          carry_q, carry_d;
    logic [KW-1:0] k_q, k_d;
    logic [W-1:0]  s_q, s_d;
    logic          co_q, co_d;

    logic [N-1:0]  slice_s;
    logic          slice_co;
    logic [W-1:0]  b_load;
    logic          c_load;
    logic [W-1:0]  r_full;

    adder_rc #(.N(N)) u_slice (
        .a  (a_q[N-1:0]),
        .b  (b_q[N-1:0]),
        .ci (carry_q),
        .s  (slice_s),
        .co (slice_co)
    );

    // Subtraction is a + ~b + 1, so it reuses the add path with a forced carry-in.
    always_comb begin
`ifdef ADDER_SEQ_SUB_EN
        b_load = sub ? ~b : b;
        c_load = sub ? 1'b1 : ci;
`else
        b_load = b;
        c_load = ci;
`endif
    end

    assign r_full = {slice_s, r_q};

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        r_d     = r_q;
        carry_d = carry_q;
        k_d     = k_q;
        s_d     = s_q;
        co_d    = co_q;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    state_d = RUN;
                    a_d     = a;
                    b_d     = b_load;
                    carry_d = c_load;
                    k_d     = '0;
                end
            end
            RUN: begin
                // Slices enter at the top; after M shifts slice 0 sits at bit 0.
                r_d     = r_full[W-1:N];
                a_d     = a_q >> N;
                b_d     = b_q >> N;
                carry_d = slice_co;
                k_d     = k_q + 1'b1;
                if (k_q == K_LAST) begin
                    state_d = DONE;
                    s_d     = r_full;
                    co_d    = slice_co;
                    k_d     = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            carry_q <= 1'b0;
            k_q     <= '0;
            s_q     <= '0;
            co_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            r_q     <= r_d;
            carry_q <= carry_d;
            k_q     <= k_d;
            s_q     <= s_d;
            co_q    <= co_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign s    = s_q;
    assign co   = co_q;

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// tb/tb_adder_seq_ctrl.sv - scoreboard bench for adder_seq_ctrl with N=4, M=4
module tb_adder_seq_ctrl;

    localparam int N = 4;
    localparam int M = 4;
    localparam int W = N * M;

    typedef struct {
        logic [W-1:0] s;
        logic         co;
    } exp_t;

    logic         clock = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic         busy;
    logic         done;
    logic [W-1:0] s;
    logic         co;
`ifdef ADDER_SEQ_SUB_EN
    logic         sub;
`endif

    exp_t sb[$];
    logic exp_busy;
    logic exp_done;
    logic tb_done;
    int   n_run;
    int   n_fail;

    adder_seq_ctrl #(.N(N), .M(M)) dut (
        .clock (clock),
        .reset (reset),
`ifdef ADDER_SEQ_SUB_EN
        .sub   (sub),
`endif
        .start (start),
        .a     (a),
        .b     (b),
        .ci    (ci),
        .busy  (busy),
        .done  (done),
        .s     (s),
        .co    (co)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every falling edge compares handshake outputs, pops on done,
    // and otherwise requires s/co to hold the last completed result.
    initial begin
        logic [W-1:0] last_s;
        logic         last_co;
        exp_t         e;
        n_run   = 0;
        n_fail  = 0;
        last_s  = '0;
        last_co = 1'b0;
        @(negedge clock);
        while (!tb_done) begin
            if (reset) begin
                sb.delete();
                last_s  = '0;
                last_co = 1'b0;
            end
            check("busy", 32'(busy), 32'(exp_busy));
            check("done", 32'(done), 32'(exp_done));
            if (done === 1'b1) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 32'(sb.size()), 32'd1);
                end else begin
                    e = sb.pop_front();
                    check("sum", 32'(s), 32'(e.s));
                    check("carry_out", 32'(co), 32'(e.co));
                    last_s  = e.s;
                    last_co = e.co;
                end
            end else begin
                check("s_hold", 32'(s), 32'(last_s));
                check("co_hold", 32'(co), 32'(last_co));
            end
            @(negedge clock);
        end
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

    task automatic accept(input logic [W-1:0] av, input logic [W-1:0] bv, input logic civ,
                          input logic [W-1:0] es, input logic eco);
        exp_t e;
        a     = av;
        b     = bv;
        ci    = civ;
        start = 1'b1;
        e.s   = es;
        e.co  = eco;
        sb.push_back(e);
        @(posedge clock);
        #1;
        start    = 1'b0;
        exp_busy = 1'b1;
        exp_done = 1'b0;
    endtask

    // Remaining RUN edges E1..E3, then E4 into DONE, then back to IDLE.
    task automatic finish_run();
        repeat (M - 1) begin
            @(posedge clock);
            #1;
        end
        @(posedge clock);
        #1;
        exp_busy = 1'b0;
        exp_done = 1'b1;
        @(posedge clock);
        #1;
        exp_done = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        a        = '0;
        b        = '0;
        ci       = 1'b0;
`ifdef ADDER_SEQ_SUB_EN
        sub      = 1'b0;
`endif
        exp_busy = 1'b0;
        exp_done = 1'b0;
        tb_done  = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        @(posedge clock);
        #1;

        accept(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
        finish_run();
        accept(16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0);
        finish_run();

        accept(16'h0F0F, 16'h0101, 1'b0, 16'h1010, 1'b0);
        start = 1'b1;
        a     = 16'hFFFF;
        b     = 16'hFFFF;
        ci    = 1'b1;
        repeat (M - 1) begin
            @(posedge clock);
            #1;
        end
        start = 1'b0;
        @(posedge clock);
        #1;
        exp_busy = 1'b0;
        exp_done = 1'b1;
        @(posedge clock);
        #1;
        exp_done = 1'b0;

        accept(16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0);
        @(posedge clock);
        @(posedge clock);
        #2;
        reset    = 1'b1;
        exp_busy = 1'b0;
        exp_done = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        accept(16'h8000, 16'h8000, 1'b1, 16'h0001, 1'b1);
        finish_run();

        accept(16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0);
        repeat (M) begin
            @(posedge clock);
            #1;
        end
        exp_busy = 1'b0;
        exp_done = 1'b1;
        accept(16'h00FF, 16'h0F01, 1'b0, 16'h1000, 1'b0);
        finish_run();

`ifdef ADDER_SEQ_SUB_EN
        sub = 1'b1;
        accept(16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0);
        finish_run();
        accept(16'h0007, 16'h0005, 1'b0, 16'h0002, 1'b1);
        finish_run();
        sub = 1'b0;
`endif

        repeat (2) @(posedge clock);
        #1;
        tb_done = 1'b1;
    end

endmodule
